prm_reg_write_arbiter: RTL
==========================

// Module: prm_reg_write_arbiter
// PURPOSE
//   Round-robin arbiter sharing one WIDTH-bit holding register among N requesters.
//   Each requester can ask for a write (load wdata) or a clear (load zero).
//   A requester can also lock the register for a burst of writes.
//   Sits in front of a shared parameter/status register. It replaces a per-client
//   register with clear, and provides the single write path plus ack pulses.
// PARAMETERS
//   N      4  number of requesters (>=2)
//   WIDTH  8  data width of the shared register
// PORTS
//   clk      in   1        clock, all state updates on posedge
//   rst      in   1        synchronous reset, active-high
//   req      in   N        per-requester access request, level
//   clr_req  in   N        per-requester clear qualifier (valid only with req)
//   lock     in   N        per-requester lock request (valid only with req)
//   wdata    in   N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
//   gnt      out  N        one-hot ack pulse; the write of that requester is in q this cycle
//   owner    out  clog2(N) index of the last granted requester
//   busy     out  1        1 while in LOCKED state
//   q        out  WIDTH    shared register value
// BEHAVIOUR
// - Reset (rst=1 at posedge)
//   - gnt=0, owner=0, busy=0, q=0, ptr=0, state=IDLE.
//   - Applies from any state, including mid-burst in LOCKED; the lock is dropped.
// - State IDLE, at each posedge
//   - Eligible requester: req[i]=1 AND gnt[i]=0 in the current cycle.
//     A just-granted requester is masked for one edge. It may hold req one cycle
//     after its ack without a double write.
//   - Winner w: the first eligible index scanning ptr, ptr+1, ... mod N.
//   - If w exists:
//     - gnt <= onehot(w); owner <= w; ptr <= (w+1) mod N.
//     - q <= clr_req[w] ? 0 : wdata[w].
//     - state <= lock[w] ? LOCKED : IDLE; busy follows state.
//   - If no eligible requester: gnt <= 0; q, ptr and owner are held.
// - State LOCKED (owner w), at each posedge
//   - lock[w]=0: state <= IDLE, gnt <= 0, no write.
//     The next grant is no earlier than the following edge.
//   - lock[w]=1 and req[w]=1:
//     - q <= clr_req[w] ? 0 : wdata[w]; gnt <= onehot(w).
//     - No masking, so a write every cycle is allowed (gnt acts as a per-beat ack).
//   - lock[w]=1 and req[w]=0: gnt <= 0; q is held; stays LOCKED.
//   - Requests from all other requesters are ignored and not queued; ptr is unchanged.
// - Latency and fairness
//   - Latency from req to gnt/q is 1 edge when uncontended.
//   - Worst-case wait is N-1 grants, excluding locked bursts.
// - Other rules
//   - clr_req or lock without req: ignored.
//   - clr_req and a write on the same request: clear wins, q=0.
//   - gnt is never multi-hot. q changes only on an edge that also asserts gnt, or on reset.
//   - Widths: ptr and owner are clog2(N) bits. ptr wraps N-1 -> 0 explicitly
//     (N need not be a power of 2).
// TESTING
// 1. Reset check: rst=1 for 2 cycles, with req=4'b1111 held -> gnt=0, q=0, busy=0, owner=0 throughout.
// 2. Round-robin: N=4, req=4'b1111 held, wdata_i=8'h10+i, no lock/clr ->
//    gnt sequence 0001,0010,0100,1000,0001; q = 10,11,12,13,10.
// 3. Mask and clear: req[2]=1 held alone, clr_req[2]=1 -> gnt[2]=1 every other cycle; q=00.
//    Then clr_req=0, wdata_2=AA -> q=AA.
// 4. Lock burst: requester 1 req+lock for 4 cycles, wdata_1 = 01,02,03,04, req[3]=1 held ->
//    gnt[1] on 4 consecutive cycles, q=01..04, busy=1.
//    Drop lock -> one idle edge, then gnt[3]=1.
// 5. Reset mid-lock: rst=1 during burst from test 4 -> next cycle busy=0, q=0, gnt=0.
//    Then first grant goes to index 0 if requesting.
// 6. Wrap and non-power-of-2: N=3, ptr=2, req=3'b011 -> gnt=001, owner=0, ptr=1.

Source files
------------

// File: rtl/prm_reg_write_arbiter.sv
// prm_reg_write_arbiter
// Round-robin arbiter that gives N requesters one shared WIDTH-bit holding
// register. A granted requester loads its wdata, or zero when clr_req is set.
// A requester that also raises lock keeps the register for a burst of writes.
//
// Handshake: req is a level request. gnt is a one-cycle, one-hot ack. While
// gnt[i] is high, q already holds the value that requester i wrote on that
// edge. In IDLE, a requester granted on the previous edge is masked for one
// edge, so it can keep req high for one cycle after its ack without writing
// twice. In LOCKED there is no masking, so gnt acks each beat of the burst.
//
// busy mirrors the FSM state (1 = LOCKED), so the state is visible on a port.
module prm_reg_write_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           clr_req,
    input  logic [N-1:0]           lock,
    input  logic [N*WIDTH-1:0]     wdata,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [PW-1:0]     owner_n;
    logic [N-1:0]      gnt_n;
    logic [WIDTH-1:0]  q_n;

    logic [N-1:0]      eligible;
    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     cand;
    logic [WIDTH-1:0]  win_data;
    logic [WIDTH-1:0]  own_data;

    // A requester acked on the previous edge sits out this edge.
    assign eligible = req & ~gnt;
    assign busy     = (state == LOCKED);
    assign win_data = clr_req[win]   ? '0 : wdata[win*WIDTH +: WIDTH];
    assign own_data = clr_req[owner] ? '0 : wdata[owner*WIDTH +: WIDTH];

    // Find the first eligible index, scanning from ptr with explicit wrap at N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(ptr) + k >= N) begin
                cand = PW'(int'(ptr) + k - N);
            end else begin
                cand = PW'(int'(ptr) + k);
            end
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next state, next grant and the write path for both FSM states.
    always_comb begin
        state_n = state;
        gnt_n   = '0;
        owner_n = owner;
        ptr_n   = ptr;
        q_n     = q;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n[win] = 1'b1;
                    owner_n    = win;
                    ptr_n      = (win == PW'(N - 1)) ? '0 : win + PW'(1);
                    q_n        = win_data;
                    state_n    = lock[win] ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // Only the owner is serviced. Other requests are neither
                // granted nor remembered, and ptr does not move.
                if (!lock[owner]) begin
                    state_n = IDLE;
                end else if (req[owner]) begin
                    gnt_n[owner] = 1'b1;
                    q_n          = own_data;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            gnt   <= gnt_n;
            q     <= q_n;
        end
    end

endmodule
